// File: rtl/perceptron_pkg.sv
// Shared types and default sizing for the perceptron parameter loader.
package perceptron_pkg;

  localparam int N_NEURONS_DEF = 6;
  localparam int W_WIDTH_DEF   = 4;
  localparam int B_WIDTH_DEF   = 6;

  // One neuron's parameters as carried on the stream, w1 in the LSBs.
  typedef struct packed {
    logic [B_WIDTH_DEF-1:0] bias;
    logic [W_WIDTH_DEF-1:0] w2;
    logic [W_WIDTH_DEF-1:0] w1;
  } param_beat_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    DRAIN    = 3'd2,
    COMMIT   = 3'd3,
    ERR_DONE = 3'd4
  } loader_state_t;

endpackage

// File: rtl/perceptron_param_loader_if.sv
// Valid/ready parameter stream: one neuron {bias, w2, w1} per beat.
interface perceptron_param_loader_if
  import perceptron_pkg::*;
#(
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF
);
  localparam int D_WIDTH = B_WIDTH + 2 * W_WIDTH;

  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] in_data;
  logic               in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/param_slot.sv
// One neuron's shadow (being loaded) and active (seen by the layer) registers.
module param_slot #(
  parameter int W_WIDTH = 4,
  parameter int B_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic               commit_i,
  input  logic [W_WIDTH-1:0] w1_i,
  input  logic [W_WIDTH-1:0] w2_i,
  input  logic [B_WIDTH-1:0] bias_i,
  output logic [W_WIDTH-1:0] w1_o,
  output logic [W_WIDTH-1:0] w2_o,
  output logic [B_WIDTH-1:0] bias_o
);

  logic [W_WIDTH-1:0] w1_sh_q, w2_sh_q;
  logic [B_WIDTH-1:0] bias_sh_q;
  logic [W_WIDTH-1:0] w1_act_q, w2_act_q;
  logic [B_WIDTH-1:0] bias_act_q;

  // Shadow capture on an accepted beat addressed to this slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1_sh_q   <= '0;
      w2_sh_q   <= '0;
      bias_sh_q <= '0;
    end else if (we_i) begin
      w1_sh_q   <= w1_i;
      w2_sh_q   <= w2_i;
      bias_sh_q <= bias_i;
    end
  end

  // Active set only moves on the commit edge, so the layer never sees a partial set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1_act_q   <= '0;
      w2_act_q   <= '0;
      bias_act_q <= '0;
    end else if (commit_i) begin
      w1_act_q   <= w1_sh_q;
      w2_act_q   <= w2_sh_q;
      bias_act_q <= bias_sh_q;
    end
  end

  assign w1_o   = w1_act_q;
  assign w2_o   = w2_act_q;
  assign bias_o = bias_act_q;

endmodule

// File: rtl/perceptron_param_loader.sv
// Frame-based parameter loader: collects N_NEURONS beats in shadow slots and
// commits them atomically; short or long frames are drained and discarded.
module perceptron_param_loader
  import perceptron_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int W_WIDTH   = W_WIDTH_DEF,
  parameter int B_WIDTH   = B_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  perceptron_param_loader_if.slave       in_if,
  output logic [N_NEURONS*W_WIDTH-1:0]   w1_flat,
  output logic [N_NEURONS*W_WIDTH-1:0]   w2_flat,
  output logic [N_NEURONS*B_WIDTH-1:0]   bias_flat,
  output logic                           params_valid,
  output logic                           commit_pulse,
  output logic                           frame_err
);

  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NEURONS - 1);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             params_valid_q, params_valid_d;
  logic             commit_pulse_q, commit_pulse_d;
  logic             frame_err_q, frame_err_d;
  logic             load_en, commit_en, accept;

  assign in_if.in_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN);
  assign accept         = in_if.in_valid && in_if.in_ready;

  // State, beat index and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      params_valid_q <= 1'b0;
      commit_pulse_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      params_valid_q <= params_valid_d;
      commit_pulse_q <= commit_pulse_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Frame parsing: count beats, classify short/exact/long frames.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    load_en        = 1'b0;
    commit_en      = 1'b0;
    params_valid_d = params_valid_q;
    commit_pulse_d = 1'b0;
    frame_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load_en = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          if (in_if.in_last)       state_d = ERR_DONE;
          else if (N_NEURONS > 1)  state_d = LOAD;
          else                     state_d = DRAIN;
        end
      end
      LOAD: begin
        if (accept) begin
          load_en = 1'b1;
          if (idx_q == IDX_LAST) begin
            // Index holds here; it is cleared on the way back to IDLE.
            state_d = in_if.in_last ? COMMIT : DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (in_if.in_last) state_d = ERR_DONE;
          end
        end
      end
      DRAIN: begin
        if (accept && in_if.in_last) state_d = ERR_DONE;
      end
      COMMIT: begin
        commit_en      = 1'b1;
        commit_pulse_d = 1'b1;
        params_valid_d = 1'b1;
        idx_d          = '0;
        state_d        = IDLE;
      end
      ERR_DONE: begin
        frame_err_d = 1'b1;
        idx_d       = '0;
        state_d     = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_slot
      param_slot #(
        .W_WIDTH (W_WIDTH),
        .B_WIDTH (B_WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (load_en && (idx_q == IDX_W'(gi))),
        .commit_i (commit_en),
        .w1_i     (in_if.in_data[W_WIDTH-1:0]),
        .w2_i     (in_if.in_data[2*W_WIDTH-1:W_WIDTH]),
        .bias_i   (in_if.in_data[2*W_WIDTH+B_WIDTH-1:2*W_WIDTH]),
        .w1_o     (w1_flat[gi*W_WIDTH +: W_WIDTH]),
        .w2_o     (w2_flat[gi*W_WIDTH +: W_WIDTH]),
        .bias_o   (bias_flat[gi*B_WIDTH +: B_WIDTH])
      );
    end
  endgenerate

  assign params_valid = params_valid_q;
  assign commit_pulse = commit_pulse_q;
  assign frame_err    = frame_err_q;

endmodule
